spi_cfg_master: RTL and testbench

SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

---
 rtl/spi_cfg_master.sv | 159 +++++++++++++++
 tb/tb_spi_cfg_master.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_cfg_master.sv
// Two-requester SPI (mode 0) register-write master: 16-bit frames {1, addr[6:0], data[7:0]}.
// Define SPI_CFG_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module spi_cfg_master #(
  parameter int HALF_PERIOD = 4,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
  output logic       done,
  output logic       grant_id
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [7:0] HP_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [14:0] shreg;
  logic        win_id;
  logic        win_valid;
  logic        accept;
  logic [15:0] next_frame;

  // Handshake: a request transfers on the rising clk edge where valid and ready
  // are both high; ready is only offered in IDLE, to the arbitration winner.
`ifdef SPI_CFG_ARB_RR_EN
  logic rr_ptr;

  always_comb begin
    win_id = 1'b0;
    if (req0_valid && req1_valid) win_id = rr_ptr;
    else if (req1_valid)          win_id = 1'b1;
  end

  // rr_ptr names the requester preferred on the next contended grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~win_id;
    end
  end
`else
  assign win_id = ~req0_valid & req1_valid;
`endif

  assign win_valid  = req0_valid | req1_valid;
  assign accept     = rst_n && (state == ST_IDLE) && win_valid;
  assign req0_ready = accept & ~win_id;
  assign req1_ready = accept & win_id;
  assign busy       = (state != ST_IDLE);
  assign next_frame = win_id ? {1'b1, req1_addr, req1_data}
                             : {1'b1, req0_addr, req0_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      nCS      <= 1'b1;
      SCLK     <= 1'b0;
      COPI     <= 1'b0;
      done     <= 1'b0;
      grant_id <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            shreg    <= next_frame[14:0];
            COPI     <= next_frame[15];
            nCS      <= 1'b0;
            grant_id <= win_id;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (div_cnt == HP_LAST) begin
            div_cnt <= '0;
            SCLK    <= 1'b1;
            bit_cnt <= 5'd1;
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_SHIFT: begin
          if (div_cnt == HP_LAST) begin
            div_cnt <= '0;
            if (SCLK) begin
              SCLK  <= 1'b0;
              COPI  <= shreg[14];
              shreg <= {shreg[13:0], 1'b0};
            end else if (bit_cnt == 5'd16) begin
              // The low half-period after the 16th bit completes without a 17th edge.
              state <= ST_HOLD;
            end else begin
              SCLK    <= 1'b1;
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_HOLD: begin
          if (div_cnt == HP_LAST) begin
            div_cnt <= '0;
            nCS     <= 1'b1;
            COPI    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_GAP;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        ST_GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          nCS     <= 1'b1;
          SCLK    <= 1'b0;
          COPI    <= 1'b0;
          div_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master with a behavioural SPI register peripheral.
module tb_spi_cfg_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       ncs, sclk, copi, busy, done, grant_id;

  int tests = 0;
  int fails = 0;

  spi_cfg_master #(.HALF_PERIOD(4), .GAP_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .nCS(ncs), .SCLK(sclk), .COPI(copi), .busy(busy), .done(done), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Register peripheral: latches a write when nCS rises after exactly 16 bits.
  logic [7:0]  regs [0:127];
  logic [15:0] p_sh = '0;
  int          p_bits = 0;
  always @(negedge ncs) p_bits = 0;
  always @(posedge sclk) if (!ncs) begin p_sh = {p_sh[14:0], copi}; p_bits++; end
  always @(posedge ncs) if (p_bits == 16 && p_sh[15]) regs[p_sh[14:8]] = p_sh[7:0];

  // Bus monitor, sampled on the falling clk edge.
  int          low_cnt = 0, high_cnt = 0, rise_cnt = 0, frames_seen = 0;
  int          done_cnt = 0, min_gap = 1000, ready1_hi = 0;
  int          last_low = 0, last_rise = 0;
  logic [15:0] cap = '0, last_cap = '0;
  logic        last_grant = 1'b0, sclk_q = 1'b0, ncs_q = 1'b1;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (req1_ready === 1'b1) ready1_hi++;
    if (ncs_q && !ncs) begin
      if (high_cnt < min_gap) min_gap = high_cnt;
      low_cnt = 0; rise_cnt = 0; cap = '0; last_grant = grant_id;
    end
    if (!ncs) begin
      low_cnt++;
      if (sclk && !sclk_q) begin rise_cnt++; cap = {cap[14:0], copi}; end
    end else begin
      high_cnt = ncs_q ? high_cnt + 1 : 1;
    end
    if (!ncs_q && ncs) begin
      last_low = low_cnt; last_rise = rise_cnt; last_cap = cap; frames_seen++;
    end
    sclk_q = sclk; ncs_q = ncs;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input bit idx, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    if (idx) begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
    else     begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
    #1;
    while (!(idx ? req1_ready : req0_ready) && n < 300) begin @(negedge clk); #1; n++; end
    check("accept_timeout", 32'(n < 300), 32'd1);
    @(posedge clk); #1;
    if (idx) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int start = frames_seen;
    int n = 0;
    while (frames_seen == start && n < 2000) begin @(posedge clk); n++; end
    check(tag, 32'(frames_seen != start), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    #1;
    check("idle_timeout", 32'(n < 500), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  exp_g_bits;
    logic [15:0] exp_cap;
    int d0, n;
    foreach (regs[i]) regs[i] = 8'h00;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'h00;
    req1_valid = 1'b1; req1_addr = 7'h00; req1_data = 8'h00;

    // Reset values, with both requesters valid to show ready stays low.
    repeat (3) @(negedge clk);
    #1;
    check("rst_ncs", ncs, 1); check("rst_sclk", sclk, 0); check("rst_copi", copi, 0);
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_grant", grant_id, 0);
    check("rst_ready0", req0_ready, 0); check("rst_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Single write: addr 0x04, data 0x80.
    d0 = done_cnt;
    send_req(0, 7'h04, 8'h80);
    check("busy_in_frame", busy, 1);
    wait_frame("frame1_timeout");
    check("frame1_bits", last_cap, 16'h8480);
    check("frame1_ncs_low", last_low, 136);
    check("frame1_rises", last_rise, 16);
    check("frame1_grant", last_grant, 0);
    wait_idle();
    check("frame1_done_pulses", done_cnt - d0, 1);
    check("frame1_reg04", regs[4], 8'h80);
    check("idle_copi", copi, 0); check("idle_sclk", sclk, 0); check("idle_ncs", ncs, 1);

    // Arbitration from a fresh reset with both requesters held valid.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
`ifdef SPI_CFG_ARB_RR_EN
    exp_g_bits = 4'b1010;
`else
    exp_g_bits = 4'b0000;
`endif
    ready1_hi = 0; min_gap = 1000;
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 7'h00; req0_data = 8'h11;
    req1_valid = 1'b1; req1_addr = 7'h01; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      wait_frame("arb_frame_timeout");
      exp_cap = exp_g_bits[i] ? 16'h8122 : 16'h8011;
      check($sformatf("arb_grant%0d", i), last_grant, exp_g_bits[i]);
      check($sformatf("arb_bits%0d", i), last_cap, exp_cap);
      check($sformatf("arb_rises%0d", i), last_rise, 16);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    check("arb_min_gap_ok", 32'(min_gap >= 8), 32'd1);
`ifdef SPI_CFG_ARB_RR_EN
    check("arb_ready1_seen", 32'(ready1_hi > 0), 32'd1);
    check("arb_reg01", regs[1], 8'h22);
`else
    check("arb_ready1_never", ready1_hi, 0);
`endif
    check("arb_reg00", regs[0], 8'h11);

    // Reset just after the 5th SCLK rising edge aborts the frame.
    send_req(0, 7'h04, 8'h55);
    d0 = done_cnt;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (rise_cnt != 5 && n < 500);
    check("abort_reach_edge5", rise_cnt, 5);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ncs", ncs, 1); check("abort_sclk", sclk, 0);
    check("abort_copi", copi, 0); check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_reg04", regs[4], 8'h80);
    @(negedge clk); rst_n = 1'b1;

    // req1 data changes one cycle after acceptance; the frame keeps 0x3C.
    d0 = done_cnt;
    send_req(1, 7'h05, 8'h3C);
    @(posedge clk); #1;
    req1_data = 8'hFF;
    wait_frame("frame5_timeout");
    check("frame5_bits", last_cap, 16'h853C);
    check("frame5_grant", last_grant, 1);
    check("frame5_ncs_low", last_low, 136);
    wait_idle();
    check("frame5_grant_held", grant_id, 1);
    check("frame5_done_pulses", done_cnt - d0, 1);
    check("frame5_reg05", regs[5], 8'h3C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
